mdu: RTL and testbench
======================

# mdu

Multiply/divide unit in the EX stage of the P7 pipeline. Accepts `mult`/`multu`/`div`/`divu`/`mthi`/`mtlo` from EX and holds the architectural HI/LO registers. It also drives the `start`/`busy` pair that the hazard unit uses to stall HI/LO-class instructions in ID. Long operations are iterative in time: fixed multi-cycle latency, with HI/LO committed at the end.

## Interface
- `MULT_CYCLES`, 5, busy cycles for `mult`/`multu`
- `DIV_CYCLES`, 10, busy cycles for `div`/`divu`

- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-low; sampled on rising edge of `clk`
- `start`  in  1  EX holds a valid MD-class instruction this cycle
- `MDOp`  in  3  operation code; shared constants in `lib.v`
- `cancel`  in  1  interrupt/exception flush this cycle (`intReq`)
- `A`  in  32  rs operand (forwarded)
- `B`  in  32  rt operand (forwarded)
- `busy`  out  1  long operation in progress
- `HI`  out  32  architectural HI, registered
- `LO`  out  32  architectural LO, registered

## Operation
- **MDOp codes** (from `lib.v`): `MD_NONE`=0, `MD_MULT`=1, `MD_MULTU`=2, `MD_DIV`=3, `MD_DIVU`=4, `MD_MTHI`=5, `MD_MTLO`=6.
- **Accept condition:** an operation is accepted when `start && !cancel && !busy`.
  - `start` with `busy`=1 is ignored. The hazard unit prevents this case; the bench asserts it never occurs.
  - `cancel` only qualifies `start`. An operation already running is older than the interrupt victim, so it completes and commits normally.
- **FSM states:** IDLE, RUN.
  - IDLE → RUN on accept of mult/multu/div/divu.
  - RUN → IDLE when the counter reaches 1.
- **Counter:** loaded with `MULT_CYCLES` or `DIV_CYCLES` on accept, decremented each cycle in RUN.
- **Operand capture:** the result is computed from `A`/`B` captured at accept into pending `pend_hi`/`pend_lo`. `A`/`B` are don't-care afterwards.
- **mthi / mtlo:** on accept, write HI or LO from `A` at the same edge. `busy` is not raised.
- **mult:** signed 32×32 → 64-bit product; HI = upper 32 bits, LO = lower 32 bits.
- **multu:** same as `mult`, unsigned.
- **div:** signed division; LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- **divu:** unsigned division, LO = quotient, HI = remainder.
- **Divide by zero:** the op runs the full `DIV_CYCLES`, then HI/LO are left unchanged.
- **Reset:** HI=0, LO=0, `busy`=0, state IDLE, counter 0, pending registers 0.
  - A reset during RUN aborts the operation and no commit occurs.

## Timing
- **mthi/mtlo:** accepted in cycle 0; HI/LO show the new value in cycle 1.
- **Long op:** accepted in cycle 0.
  - `busy`=1 in cycles 1..N (N = `MULT_CYCLES` or `DIV_CYCLES`).
  - HI/LO update at the edge ending cycle N and are valid with `busy`=0 in cycle N+1.
- **Back-to-back:** a new op may be accepted in cycle N+1.
- **Reads:** `mfhi`/`mflo` read HI/LO combinationally from the registered outputs. The hazard unit's stall on `start || busy` guarantees no read sees stale data.
- **HI/LO stability:** unchanged during RUN until commit.

## Structure
- **Shared package:** `MD_*` op codes and default latencies go in `lib.v` as `define`s, alongside the existing instruction IDs.
- **Sub-module `mdu_arith`:** purely combinational.
  - Inputs: op, A, B.
  - Outputs: 64-bit {hi, lo} and a `div_zero` flag.
- **`mdu` itself:** the FSM, counter, pending registers and HI/LO.

## Test plan
- **Signed vs unsigned multiply:** mult A=0xFFFFFFFF, B=2 → `busy` high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. multu with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- **Signed divide:** div A=0xFFFFFFF9 (−7), B=2 → `busy` high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- **Overflow and zero divisor:** div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0. divu 7/0 with prior HI=0x11, LO=0x22 → after 10 cycles HI=0x11, LO=0x22.
- **mthi/mtlo and operand capture:**
  - mthi A=0xDEADBEEF → HI=0xDEADBEEF next cycle, `busy` stays 0.
  - mtlo directly after → LO updated, HI unchanged.
  - Operand changes during RUN have no effect on the result.
- **Cancel:**
  - `start`+`cancel` together with multu 3×4 → `busy` never rises, HI/LO unchanged.
  - `cancel` pulsed mid-RUN of mult 3×4 → completes with LO=12, HI=0.
- **Reset mid-operation:** reset low in cycle 3 of a div → next cycle `busy`=0, HI=LO=0. A following mult 6×7 gives LO=42 after 5 cycles.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - md_op_e     : MDOp encodings driven by EX
//   - mdu_state_e : control FSM states
//   - default multiply/divide latencies and the busy-counter type
package mdu_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  localparam int unsigned MD_MULT_CYCLES_DEF = 32'd5;
  localparam int unsigned MD_DIV_CYCLES_DEF  = 32'd10;

  // Wide enough for any sensible latency setting.
  localparam int unsigned CNT_W = 32'd8;
  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/mdu_if.sv
// mdu_if: EX-stage <-> MDU handshake and HI/LO result bus.
//   start  : EX holds a valid MD-class instruction
//   MDOp   : operation code (mdu_pkg::md_op_e encoding)
//   cancel : interrupt/exception flush, qualifies start only
//   A, B   : forwarded rs / rt operands
//   busy   : long operation in progress
//   HI, LO : architectural HI/LO registers
// master = EX / pipeline side, slave = MDU.
interface mdu_if;
  logic        start;
  logic [2:0]  MDOp;
  logic        cancel;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output start, MDOp, cancel, A, B,
    input  busy, HI, LO
  );

  modport slave (
    input  start, MDOp, cancel, A, B,
    output busy, HI, LO
  );
endinterface

// File: rtl/mdu_arith.sv
// mdu_arith: purely combinational multiply/divide datapath.
//   op_i       : MDOp code
//   a_i, b_i   : operands (A = dividend / multiplicand)
//   res_o      : {hi, lo}; product, or {remainder, quotient}; 0 for non-arith ops
//   div_zero_o : divide op with a zero divisor (result must not be committed)
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] res_o,
  output logic        div_zero_o
);

  logic        a_neg_s;
  logic        b_neg_s;
  logic        b_zero_s;
  logic [31:0] a_mag_s;
  logic [31:0] b_mag_s;
  logic [31:0] sdiv_b_s;
  logic [31:0] udiv_b_s;
  logic [31:0] squo_mag_s;
  logic [31:0] srem_mag_s;
  logic [31:0] squo_s;
  logic [31:0] srem_s;
  logic [31:0] uquo_s;
  logic [31:0] urem_s;
  logic [63:0] prod_sgn_s;
  logic [63:0] prod_uns_s;

  // Low 64 bits of a product of sign-extended operands equal the signed product.
  assign prod_sgn_s = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
  assign prod_uns_s = {32'd0, a_i} * {32'd0, b_i};

  assign a_neg_s  = a_i[31];
  assign b_neg_s  = b_i[31];
  assign b_zero_s = (b_i == 32'd0);
  assign a_mag_s  = a_neg_s ? (32'd0 - a_i) : a_i;
  assign b_mag_s  = b_neg_s ? (32'd0 - b_i) : b_i;

  // Substitute 1 for a zero divisor so the dividers stay defined; the result
  // is discarded anyway because div_zero_o blocks the commit.
  assign sdiv_b_s = b_zero_s ? 32'd1 : b_mag_s;
  assign udiv_b_s = b_zero_s ? 32'd1 : b_i;

  // Signed divide on magnitudes: 0x80000000 has magnitude 0x80000000 as an
  // unsigned value, so the overflow case 0x80000000 / -1 falls out as
  // quotient 0x80000000, remainder 0 with no special handling.
  assign squo_mag_s = a_mag_s / sdiv_b_s;
  assign srem_mag_s = a_mag_s % sdiv_b_s;
  assign squo_s     = (a_neg_s ^ b_neg_s) ? (32'd0 - squo_mag_s) : squo_mag_s;
  assign srem_s     = a_neg_s ? (32'd0 - srem_mag_s) : srem_mag_s;

  assign uquo_s = a_i / udiv_b_s;
  assign urem_s = a_i % udiv_b_s;

  // Result select by operation.
  always_comb begin
    res_o      = 64'd0;
    div_zero_o = 1'b0;
    case (op_i)
      MD_MULT:  res_o = prod_sgn_s;
      MD_MULTU: res_o = prod_uns_s;
      MD_DIV: begin
        res_o      = {srem_s, squo_s};
        div_zero_o = b_zero_s;
      end
      MD_DIVU: begin
        res_o      = {urem_s, uquo_s};
        div_zero_o = b_zero_s;
      end
      default: begin
        res_o      = 64'd0;
        div_zero_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mdu.sv
// mdu: EX-stage multiply/divide unit holding architectural HI/LO.
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous, active-low reset
//   bus   : mdu_if.slave (start/MDOp/cancel/A/B in; busy/HI/LO out)
// mthi/mtlo write HI/LO at the accepting edge. mult/multu/div/divu capture
// their result into pending registers at accept, hold busy for a fixed
// number of cycles and then commit HI/LO (skipped on divide by zero).
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic  clk,
  input  logic  reset,
  mdu_if.slave  bus
);

  mdu_state_e  state_q, state_d;
  cnt_t        cnt_q, cnt_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic        pend_dz_q, pend_dz_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;

  logic        accept_s;
  logic [63:0] arith_res_s;
  logic        arith_dz_s;

  mdu_arith u_arith (
    .op_i       (bus.MDOp),
    .a_i        (bus.A),
    .b_i        (bus.B),
    .res_o      (arith_res_s),
    .div_zero_o (arith_dz_s)
  );

  // cancel only qualifies a new start; a running op always completes.
  assign accept_s = bus.start && !bus.cancel && !busy_q;

  // Next-state logic for the FSM, counter, pending result and HI/LO.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_dz_d = pend_dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          case (bus.MDOp)
            MD_MTHI: hi_d = bus.A;
            MD_MTLO: lo_d = bus.A;
            MD_MULT, MD_MULTU: begin
              state_d   = ST_RUN;
              busy_d    = 1'b1;
              cnt_d     = cnt_t'(MULT_CYCLES);
              pend_hi_d = arith_res_s[63:32];
              pend_lo_d = arith_res_s[31:0];
              pend_dz_d = 1'b0;
            end
            MD_DIV, MD_DIVU: begin
              state_d   = ST_RUN;
              busy_d    = 1'b1;
              cnt_d     = cnt_t'(DIV_CYCLES);
              pend_hi_d = arith_res_s[63:32];
              pend_lo_d = arith_res_s[31:0];
              pend_dz_d = arith_dz_s;
            end
            default: begin
              state_d = ST_IDLE;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - cnt_t'(1);
        // The cycle with counter == 1 is the last busy cycle: commit at its end.
        if (cnt_q <= cnt_t'(1)) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          if (!pend_dz_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end else begin
            hi_d = hi_q;
            lo_d = lo_q;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        cnt_d   = cnt_t'(0);
      end
    endcase
  end

  // State register; a synchronous reset also aborts any running operation.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= cnt_t'(0);
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_dz_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_dz_q <= pend_dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: table-driven directed bench for mdu plus hand sequences for
// operand capture, cancel, and reset during an operation.
module tb_mdu;
  import mdu_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  mdu_if bus ();

  mdu u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge; the op is accepted at the following posedge and the
  // task returns at the negedge of cycle 1.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic c);
    chk("start_while_busy", {31'd0, bus.busy}, 32'd0);
    bus.start  = 1'b1;
    bus.MDOp   = op;
    bus.A      = a;
    bus.B      = b;
    bus.cancel = c;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    bus.MDOp   = MD_NONE;
  endtask

  // Counts busy cycles from the current negedge; returns in the first idle cycle.
  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 64) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    checks   = 0;
    failures = 0;

    vecs[0]  = '{MD_MTHI,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h00000000, 0};
    vecs[1]  = '{MD_MTLO,  32'h12345678, 32'h0,        32'hDEADBEEF, 32'h12345678, 0};
    vecs[2]  = '{MD_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 5};
    vecs[3]  = '{MD_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 5};
    vecs[4]  = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[5]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[6]  = '{MD_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 10};
    vecs[7]  = '{MD_MTHI,  32'h00000011, 32'h0,        32'h00000011, 32'h0000000E, 0};
    vecs[8]  = '{MD_MTLO,  32'h00000022, 32'h0,        32'h00000011, 32'h00000022, 0};
    vecs[9]  = '{MD_DIVU,  32'h00000007, 32'h00000000, 32'h00000011, 32'h00000022, 10};
    vecs[10] = '{MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[11] = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
    vecs[12] = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[13] = '{MD_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002, 10};

    bus.start  = 1'b0;
    bus.MDOp   = MD_NONE;
    bus.cancel = 1'b0;
    bus.A      = 32'd0;
    bus.B      = 32'd0;
    reset      = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_hi", bus.HI, 32'd0);
    chk("reset_lo", bus.LO, 32'd0);

    for (int i = 0; i < 14; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
      wait_idle(n);
      chk($sformatf("vec%0d_cycles", i), n, vecs[i].cyc);
      chk($sformatf("vec%0d_hi", i), bus.HI, vecs[i].hi);
      chk($sformatf("vec%0d_lo", i), bus.LO, vecs[i].lo);
    end

    // Operand capture and HI/LO stability during RUN.
    issue(MD_MTHI, 32'h00005555, 32'h0, 1'b0);
    issue(MD_MULT, 32'd6, 32'd7, 1'b0);
    bus.A = 32'h0000FFFF;
    bus.B = 32'h00001234;
    @(negedge clk);
    chk("run_hi_stable", bus.HI, 32'h00005555);
    wait_idle(n);
    chk("capture_cycles", n, 32'd4);
    chk("capture_lo", bus.LO, 32'd42);
    chk("capture_hi", bus.HI, 32'd0);

    // start together with cancel is dropped.
    issue(MD_MTHI, 32'hAAAA0000, 32'h0, 1'b0);
    issue(MD_MTLO, 32'h0000BBBB, 32'h0, 1'b0);
    issue(MD_MULTU, 32'd3, 32'd4, 1'b1);
    chk("cancel_start_busy1", {31'd0, bus.busy}, 32'd0);
    repeat (6) @(negedge clk);
    chk("cancel_start_busy2", {31'd0, bus.busy}, 32'd0);
    chk("cancel_start_hi", bus.HI, 32'hAAAA0000);
    chk("cancel_start_lo", bus.LO, 32'h0000BBBB);

    // cancel during RUN does not disturb the running op.
    issue(MD_MULT, 32'd3, 32'd4, 1'b0);
    chk("cancel_run_busy", {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    wait_idle(n);
    chk("cancel_run_cycles", n, 32'd3);
    chk("cancel_run_lo", bus.LO, 32'd12);
    chk("cancel_run_hi", bus.HI, 32'd0);

    // Reset in cycle 3 of a divide aborts it.
    issue(MD_DIV, 32'd100, 32'd7, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_mid_hi", bus.HI, 32'd0);
    chk("rst_mid_lo", bus.LO, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_after_lo", bus.LO, 32'd0);
    issue(MD_MULT, 32'd6, 32'd7, 1'b0);
    wait_idle(n);
    chk("post_rst_cycles", n, 32'd5);
    chk("post_rst_lo", bus.LO, 32'd42);
    chk("post_rst_hi", bus.HI, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
